// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Opcode map, sequencer state encoding and opcode-class
//                helper functions shared by the 16-bit CPU control path.
//  Revision    : 1.0  initial multi-cycle sequencer release
// ============================================================================
package cpu_ctrl_pkg;

    // Architectural opcode field is 4 bits; wider instruction fields must
    // carry zeros above bit 3.
    localparam int c_op_bits = 4;

    localparam logic [c_op_bits-1:0] c_op_nop   = 4'h0;
    localparam logic [c_op_bits-1:0] c_op_add   = 4'h1;
    localparam logic [c_op_bits-1:0] c_op_sub   = 4'h2;
    localparam logic [c_op_bits-1:0] c_op_and   = 4'h3;
    localparam logic [c_op_bits-1:0] c_op_or    = 4'h4;
    localparam logic [c_op_bits-1:0] c_op_xor   = 4'h5;
    localparam logic [c_op_bits-1:0] c_op_shl   = 4'h6;
    localparam logic [c_op_bits-1:0] c_op_mul   = 4'h7;
    localparam logic [c_op_bits-1:0] c_op_load  = 4'h8;
    localparam logic [c_op_bits-1:0] c_op_store = 4'h9;
    localparam logic [c_op_bits-1:0] c_op_jmp   = 4'hA;
    localparam logic [c_op_bits-1:0] c_op_jz    = 4'hB;
    localparam logic [c_op_bits-1:0] c_op_halt  = 4'hF;

    // Sequencer states; 3-bit encoding, FETCH is the reset state.
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_OPERAND   = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_TRAP      = 3'd7
    } state_t;

    // Register-to-register ALU work, including the multi-cycle MUL.
    function automatic logic is_alu(input logic [c_op_bits-1:0] op);
        return (op >= c_op_add) && (op <= c_op_mul);
    endfunction

    // Opcodes that need the second operand latch. SHL shifts by one and
    // is therefore unary.
    function automatic logic is_binary(input logic [c_op_bits-1:0] op);
        return ((op >= c_op_add) && (op <= c_op_xor)) ||
               (op == c_op_mul) || (op == c_op_store);
    endfunction

    // Opcodes that use the data memory port.
    function automatic logic is_mem(input logic [c_op_bits-1:0] op);
        return (op == c_op_load) || (op == c_op_store);
    endfunction

    // Opcodes that may redirect the PC.
    function automatic logic is_branch(input logic [c_op_bits-1:0] op);
        return (op == c_op_jmp) || (op == c_op_jz);
    endfunction

    // C, D and E are unassigned and raise the trap.
    function automatic logic is_legal(input logic [c_op_bits-1:0] op);
        return (op < 4'hC) || (op == c_op_halt);
    endfunction

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : control_fsm
//  Description : Multi-cycle control sequencer. Steps each instruction
//                through FETCH/DECODE/OPERAND/EXECUTE/MEM/WRITEBACK and
//                drives datapath load/increment strobes, the memory
//                request handshake, branch, halt and illegal-opcode trap.
//  Revision    : 1.0  initial multi-cycle sequencer release
// ============================================================================
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int ALU_OP_W   = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero_flag,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ins_load,
    output logic                op1_load,
    output logic                op2_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_load,
    output logic                halted,
    output logic                trap
);

    // MUL iteration counter sized to hold 0..MUL_CYCLES-1.
    localparam int c_cnt_w = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_op_bits-1:0] r_opcode;
    logic [c_cnt_w-1:0]   r_mul_cnt;
    logic [c_op_bits-1:0] w_dec_op;
    logic                 w_upper_nz;
    logic                 w_dec_illegal;
    logic                 w_mul_last;

    assign w_dec_op = opcode[c_op_bits-1:0];

    // Any set bit above the architectural opcode field makes it illegal.
    generate
        if (OPCODE_W > c_op_bits) begin : g_upper_bits
            assign w_upper_nz = |opcode[OPCODE_W-1:c_op_bits];
        end else begin : g_no_upper_bits
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    assign w_dec_illegal = w_upper_nz || !is_legal(w_dec_op);
    assign w_mul_last    = (r_mul_cnt == c_mul_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the opcode in DECODE; later changes on the IR bus are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= w_dec_op;
        end
    end

    // Count MUL execute cycles; cleared on leaving EXECUTE so each MUL
    // starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_cnt <= '0;
        end else if ((r_state == S_EXECUTE) && (r_opcode == c_op_mul) && !w_mul_last) begin
            r_mul_cnt <= r_mul_cnt + 1'b1;
        end else begin
            r_mul_cnt <= '0;
        end
    end

    // Next-state and strobe decode. Strobes are Moore outputs except the
    // FETCH handshake and the JZ pc_load, and are all forced low in reset.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ins_load     = 1'b0;
        op1_load     = 1'b0;
        op2_load     = 1'b0;
        alu_op       = '0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_load     = 1'b0;
        halted       = 1'b0;
        trap         = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ins_load     = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (w_dec_illegal) begin
                    w_next_state = S_TRAP;
                end else if (w_dec_op == c_op_halt) begin
                    w_next_state = S_HALT;
                end else if (w_dec_op == c_op_nop) begin
                    w_next_state = S_FETCH;
                end else if (is_branch(w_dec_op)) begin
                    w_next_state = S_EXECUTE;
                end else begin
                    w_next_state = S_OPERAND;
                end
            end

            S_OPERAND: begin
                op1_load     = 1'b1;
                op2_load     = is_binary(r_opcode);
                w_next_state = is_mem(r_opcode) ? S_MEM : S_EXECUTE;
            end

            S_EXECUTE: begin
                if (is_branch(r_opcode)) begin
                    pc_load      = (r_opcode == c_op_jmp) || zero_flag;
                    w_next_state = S_FETCH;
                end else begin
                    alu_op = ALU_OP_W'(r_opcode);
                    if ((r_opcode != c_op_mul) || w_mul_last) begin
                        w_next_state = S_WRITEBACK;
                    end
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (r_opcode == c_op_store);
                if (mem_ready) begin
                    w_next_state = (r_opcode == c_op_store) ? S_FETCH : S_WRITEBACK;
                end
            end

            S_WRITEBACK: begin
                reg_load     = 1'b1;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        if (!rst_n) begin
            w_next_state = S_FETCH;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            ins_load     = 1'b0;
            op1_load     = 1'b0;
            op2_load     = 1'b0;
            alu_op       = '0;
            pc_inc       = 1'b0;
            pc_load      = 1'b0;
            reg_load     = 1'b0;
            halted       = 1'b0;
            trap         = 1'b0;
        end
    end

endmodule : control_fsm
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Directed self-checking bench for control_fsm. Instruction
//                sequences are expanded into per-cycle expected strobe
//                vectors from the instruction timing rules, then replayed
//                cycle by cycle against the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_fsm;

    // Packed strobe vector layout:
    // {mem_req, mem_we, ins_load, op1_load, op2_load, alu_op[2:0],
    //  pc_inc, pc_load, reg_load, halted, trap}
    localparam logic [12:0] c_req = 13'h1000;
    localparam logic [12:0] c_we  = 13'h0800;
    localparam logic [12:0] c_ins = 13'h0400;
    localparam logic [12:0] c_o1  = 13'h0200;
    localparam logic [12:0] c_o2  = 13'h0100;
    localparam logic [12:0] c_inc = 13'h0010;
    localparam logic [12:0] c_pl  = 13'h0008;
    localparam logic [12:0] c_rl  = 13'h0004;
    localparam logic [12:0] c_hlt = 13'h0002;
    localparam logic [12:0] c_trp = 13'h0001;

    typedef struct {
        logic [3:0]  op;
        logic        rdy;
        logic        zf;
        logic [12:0] exp;
    } ent_t;

    logic       clk;
    logic       rst_a_n;
    logic       rst_b_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       zero_flag;

    logic       mem_req_a, mem_we_a, ins_load_a, op1_load_a, op2_load_a;
    logic [2:0] alu_op_a;
    logic       pc_inc_a, pc_load_a, reg_load_a, halted_a, trap_a;
    logic       mem_req_b, mem_we_b, ins_load_b, op1_load_b, op2_load_b;
    logic [2:0] alu_op_b;
    logic       pc_inc_b, pc_load_b, reg_load_b, halted_b, trap_b;

    logic [12:0] obs_a;
    logic [12:0] obs_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ent_t q[$];

    // Instance with the default 4-cycle multiplier.
    control_fsm #(.OPCODE_W(4), .ALU_OP_W(3), .MUL_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_a_n), .opcode(opcode), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .mem_req(mem_req_a), .mem_we(mem_we_a),
        .ins_load(ins_load_a), .op1_load(op1_load_a), .op2_load(op2_load_a),
        .alu_op(alu_op_a), .pc_inc(pc_inc_a), .pc_load(pc_load_a),
        .reg_load(reg_load_a), .halted(halted_a), .trap(trap_a)
    );

    // Instance with a single-cycle multiplier.
    control_fsm #(.OPCODE_W(4), .ALU_OP_W(3), .MUL_CYCLES(1)) u_dut_m1 (
        .clk(clk), .rst_n(rst_b_n), .opcode(opcode), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .mem_req(mem_req_b), .mem_we(mem_we_b),
        .ins_load(ins_load_b), .op1_load(op1_load_b), .op2_load(op2_load_b),
        .alu_op(alu_op_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b),
        .reg_load(reg_load_b), .halted(halted_b), .trap(trap_b)
    );

    assign obs_a = {mem_req_a, mem_we_a, ins_load_a, op1_load_a, op2_load_a,
                    alu_op_a, pc_inc_a, pc_load_a, reg_load_a, halted_a, trap_a};
    assign obs_b = {mem_req_b, mem_we_b, ins_load_b, op1_load_b, op2_load_b,
                    alu_op_b, pc_inc_b, pc_load_b, reg_load_b, halted_b, trap_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: run time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] alu_bits(input logic [2:0] a);
        return {5'b0, a, 5'b0};
    endfunction

    task automatic push(input logic [3:0] op, input logic rdy, input logic zf,
                        input logic [12:0] exp);
        ent_t e;
        e.op  = op;
        e.rdy = rdy;
        e.zf  = zf;
        e.exp = exp;
        q.push_back(e);
    endtask

    // Expand one instruction into its cycle-by-cycle expected strobes.
    // fw: fetch wait cycles, mw: memory wait cycles, chg: scramble the
    // opcode bus after DECODE, tail: cycles to observe HALT/TRAP.
    task automatic model_instr(input logic [3:0] op, input int fw, input int mw,
                               input logic zf, input bit chg, input int mulc,
                               input int tail);
        logic [3:0]  later;
        logic [12:0] e;
        int          ex_n;
        later = chg ? 4'hC : op;
        for (int i = 0; i < fw; i++) push(op, 1'b0, zf, c_req);
        push(op, 1'b1, zf, c_req | c_ins | c_inc);
        push(op, 1'b1, zf, 13'h0);
        if (op >= 4'hC && op <= 4'hE) begin
            for (int i = 0; i < tail; i++) push(later, 1'b1, zf, c_trp);
        end else if (op == 4'hF) begin
            for (int i = 0; i < tail; i++) push(later, 1'b1, zf, c_hlt);
        end else if (op == 4'hA || op == 4'hB) begin
            push(later, 1'b1, zf, ((op == 4'hA) || zf) ? c_pl : 13'h0);
        end else if (op != 4'h0) begin
            e = c_o1;
            if ((op >= 4'h1 && op <= 4'h5) || op == 4'h7 || op == 4'h9) e = e | c_o2;
            push(later, 1'b1, zf, e);
            if (op <= 4'h7) begin
                ex_n = (op == 4'h7) ? mulc : 1;
                for (int i = 0; i < ex_n; i++) push(later, 1'b1, zf, alu_bits(op[2:0]));
                push(later, 1'b1, zf, c_rl);
            end else begin
                e = c_req | ((op == 4'h9) ? c_we : 13'h0);
                for (int i = 0; i < mw; i++) push(later, 1'b0, zf, e);
                push(later, 1'b1, zf, e);
                if (op == 4'h8) push(later, 1'b1, zf, c_rl);
            end
        end
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %013b exp %013b", name, cyc, got, exp);
        end
    endtask

    task automatic check_len(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s length got %0d exp %0d", name, got, exp);
        end
    endtask

    // Replay queued cycles; called at a negedge, returns at a negedge.
    task automatic play(input bit sel);
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            opcode    = e.op;
            mem_ready = e.rdy;
            zero_flag = e.zf;
            #1;
            check(sel ? "cycle_m1" : "cycle", sel ? obs_b : obs_a, e.exp);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Assert reset on instance A and confirm outputs drop at once and
    // stay idle through a clock edge.
    task automatic reset_a(input string name);
        rst_a_n = 1'b0;
        #1;
        check({name, "_now"}, obs_a, 13'h0);
        @(negedge clk);
        #1;
        check({name, "_held"}, obs_a, 13'h0);
        @(negedge clk);
    endtask

    initial begin
        rst_a_n   = 1'b0;
        rst_b_n   = 1'b0;
        opcode    = 4'h0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", obs_a, 13'h0);
        check("reset_b", obs_b, 13'h0);
        @(negedge clk);

        // ADD with ready memory: hand-pinned timing, then replayed.
        model_instr(4'h1, 0, 0, 1'b0, 1'b0, 4, 0);
        check_len("add", q.size(), 5);
        check("add_c3_alu", q[3].exp, 13'h0020);
        check("add_c2_ops", q[2].exp, 13'h0300);
        rst_a_n = 1'b1;
        play(0);

        model_instr(4'h7, 0, 0, 1'b0, 1'b1, 4, 0);
        check_len("mul", q.size(), 8);
        play(0);
        model_instr(4'h0, 0, 0, 1'b0, 1'b0, 4, 0);
        check_len("nop", q.size(), 2);
        play(0);
        model_instr(4'hA, 0, 0, 1'b0, 1'b0, 4, 0);
        check_len("jmp", q.size(), 3);
        play(0);
        model_instr(4'h8, 0, 0, 1'b0, 1'b0, 4, 0);
        check_len("load", q.size(), 5);
        play(0);
        model_instr(4'h9, 0, 0, 1'b0, 1'b0, 4, 0);
        check_len("store", q.size(), 4);
        play(0);

        // Remaining ALU ops, waits and branch variants.
        model_instr(4'h2, 1, 0, 1'b0, 1'b0, 4, 0);
        model_instr(4'h3, 0, 0, 1'b1, 1'b0, 4, 0);
        model_instr(4'h4, 2, 0, 1'b0, 1'b1, 4, 0);
        model_instr(4'h5, 0, 0, 1'b0, 1'b0, 4, 0);
        model_instr(4'h6, 0, 0, 1'b0, 1'b0, 4, 0);
        model_instr(4'h8, 0, 3, 1'b0, 1'b1, 4, 0);
        model_instr(4'h9, 1, 1, 1'b0, 1'b0, 4, 0);
        model_instr(4'hB, 0, 0, 1'b1, 1'b0, 4, 0);
        model_instr(4'hB, 0, 0, 1'b0, 1'b0, 4, 0);
        model_instr(4'hA, 0, 0, 1'b0, 1'b1, 4, 0);
        play(0);

        // Abort a MUL in its third execute cycle, then confirm a full MUL
        // still runs its complete execute count afterwards.
        model_instr(4'h7, 0, 0, 1'b0, 1'b0, 4, 0);
        repeat (3) void'(q.pop_back());
        play(0);
        reset_a("rst_mid_mul");
        model_instr(4'h7, 0, 0, 1'b0, 1'b0, 4, 0);
        rst_a_n = 1'b1;
        play(0);

        // Abort during a memory wait.
        model_instr(4'h8, 0, 5, 1'b0, 1'b0, 4, 0);
        repeat (4) void'(q.pop_back());
        play(0);
        reset_a("rst_mem_wait");

        // Illegal opcode traps and stays trapped.
        model_instr(4'hC, 0, 0, 1'b0, 1'b0, 4, 20);
        rst_a_n = 1'b1;
        play(0);
        reset_a("rst_trap");

        // HALT is absorbing with no memory requests.
        model_instr(4'hF, 0, 0, 1'b0, 1'b1, 4, 20);
        rst_a_n = 1'b1;
        play(0);
        reset_a("rst_halt");

        // Single-cycle multiplier instance.
        model_instr(4'h7, 0, 0, 1'b0, 1'b0, 1, 0);
        check_len("mul1", q.size(), 5);
        rst_b_n = 1'b1;
        play(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_control_fsm
`default_nettype wire
